// File: rtl/alu_seq.sv
// Registered, handshaked ALU with accumulator, compare and a W-step
// unsigned shift-add multiplier; result and flags hold until the next accepted op.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   control,
  input  logic [W-1:0] DATA_A,
  input  logic [W-1:0] DATA_B,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         CO,
  output logic         OVF,
  output logic         N,
  output logic         Z
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ACC = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  mcand_p;
  logic [W-1:0]    mplier_p;
  logic [2*W-1:0]  prod_p;
  logic [2*W-1:0]  prod_next;
  logic [W-1:0]    res;
  logic            res_co;
  logic            res_ovf;
  logic [W+1:0]    add_r;
  logic            accept;
  logic            mul_last;

  // W-bit add with carry-in; returns {signed overflow, carry out, sum}.
  function automatic logic [W+1:0] add_w(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0]          s;
    logic signed [W-1:0] sa, sb, ss;
    s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sa = a;
    sb = b;
    ss = s[W-1:0];
    return {((sa < 0) == (sb < 0)) && ((ss < 0) != (sa < 0)), s[W], s[W-1:0]};
  endfunction

  assign ready     = (state != S_MUL);
  assign done      = (state == S_DONE);
  assign accept    = start && ready;
  assign mul_last  = (state == S_MUL) && (cnt == CW'(W - 1));
  assign prod_next = prod_p + (mplier_p[0] ? mcand_p : '0);

  always_comb begin
    state_d = state;
    if (state == S_MUL) begin
      if (mul_last) state_d = S_DONE;
    end else if (start) begin
      state_d = (control == OP_MUL) ? S_MUL : S_DONE;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    add_r   = '0;
    res     = '0;
    res_co  = 1'b0;
    res_ovf = 1'b0;
    unique case (control)
      OP_AND: res = DATA_A & DATA_B;
      OP_OR:  res = DATA_A | DATA_B;
      OP_XOR: res = DATA_A ^ DATA_B;
      OP_ADD: add_r = add_w(DATA_A, DATA_B, 1'b0);
      OP_ACC: add_r = add_w(OUT, DATA_A, 1'b0);
      OP_SUB, OP_CMP: add_r = add_w(DATA_A, ~DATA_B, 1'b1);
      default: res = '0;
    endcase
    if (control inside {OP_ADD, OP_ACC, OP_SUB, OP_CMP}) begin
      res     = add_r[W-1:0];
      res_co  = add_r[W];
      res_ovf = add_r[W+1];
    end
  end

  // Multiplier datapath: operands shift one position per step in MUL.
  always_ff @(posedge clk) begin
    if (accept && control == OP_MUL) begin
      mcand_p  <= {{W{1'b0}}, DATA_A};
      mplier_p <= DATA_B;
      prod_p   <= '0;
    end else if (state == S_MUL) begin
      mcand_p  <= mcand_p << 1;
      mplier_p <= mplier_p >> 1;
      prod_p   <= prod_next;
    end
  end

  // Control state and architecturally visible result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      OUT    <= '0;
      OUT_HI <= '0;
      CO     <= 1'b0;
      OVF    <= 1'b0;
      N      <= 1'b0;
      Z      <= 1'b1;
    end else begin
      state <= state_d;
      if (state == S_MUL) cnt <= cnt + 1'b1;
      else if (accept)    cnt <= '0;
      if (mul_last) begin
        OUT    <= prod_next[W-1:0];
        OUT_HI <= prod_next[2*W-1:W];
        CO     <= |prod_next[2*W-1:W];
        OVF    <= 1'b0;
        N      <= prod_next[W-1];
        Z      <= (prod_next == '0);
      end else if (accept && control != OP_MUL) begin
        if (control != OP_CMP) begin
          OUT    <= res;
          OUT_HI <= '0;
        end
        CO  <= res_co;
        OVF <= res_ovf;
        N   <= res[W-1];
        Z   <= (res == '0);
      end
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked successor to the combinational ALU, parametrised in width. Adds an accumulator mode, a compare operation and a multi-cycle unsigned shift-add multiplier. Launch uses a start/ready/done handshake. Result and flags are held in registers until the next accepted operation, so the block can sit directly on a datapath bus or be driven by a sequencer FSM.

## Interface
- W, 8: operand/result width (W ≥ 2)
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset; one clock domain
- start  input  1  request; accepted on a rising edge when ready=1
- control  input  3  operation select, sampled with start
- DATA_A  input  W  operand A, sampled with start
- DATA_B  input  W  operand B, sampled with start
- ready  output  1  block can accept start this cycle
- done  output  1  OUT/OUT_HI/flags were updated by the last edge
- OUT  output  W  result (low half for MUL)
- OUT_HI  output  W  high half of MUL product; 0 after any other result-writing op
- CO, OVF, N, Z  output  1 each  carry, signed overflow, negative, zero flags (registered)

## Operation
- control encoding:
  - 000 AND: A&B
  - 001 OR: A|B
  - 010 ADD: A+B
  - 011 SUB: A−B, computed as A+~B+1
  - 100 XOR: A^B
  - 101 ACC: OUT+DATA_A, where OUT is the currently registered result
  - 110 MUL: unsigned A×B, 2W-bit product
  - 111 CMP: flags of A−B only; OUT/OUT_HI unchanged
- States: IDLE, MUL, DONE.
- IDLE or DONE, start=1, control≠110:
  - result and flags computed from the live inputs and registered on that edge
  - next state DONE
- IDLE or DONE, start=1, control=110:
  - A and B latched into internal registers; product accumulator and step counter cleared
  - next state MUL
- MUL: one shift-add step per edge, W steps in total. The W-th step writes {OUT_HI,OUT} = product and flags, then goes to DONE.
- DONE with start=0 → IDLE.
- ready = (state ≠ MUL). start while ready=0 is ignored; latched operands are not disturbed.
- done = (state == DONE).
- Flag rules, registered together with the result:
  - ADD/ACC/SUB/CMP: CO = carry out of the W-bit add (SUB/CMP: CO=1 means no borrow); OVF = two's-complement overflow of the add
  - AND/OR/XOR/MUL: OVF = 0
  - AND/OR/XOR: CO = 0
  - MUL: CO = |OUT_HI (product exceeds W bits)
  - N = MSB of the W-bit result. For CMP this is the MSB of A−B, not of OUT.
  - Z = (result == 0), evaluated over the full 2W-bit {OUT_HI,OUT} for MUL and over the W-bit difference for CMP
- ACC wraps modulo 2^W. The carry is reported in CO only and is not accumulated into OUT_HI.
- ACC immediately after MUL uses the low half OUT only and clears OUT_HI.

## Timing
- Reset (asynchronous, any state):
  - state = IDLE, step counter = 0
  - OUT = 0, OUT_HI = 0, CO = OVF = N = 0, Z = 1
  - done = 0, ready = 1
- Single-cycle ops:
  - start sampled at edge k; result valid and done=1 after edge k
  - one start per cycle is sustainable; done stays high across back-to-back accepted ops
- MUL:
  - start at edge k; ready=0 after edges k … k+W−1
  - result and done=1 after edge k+W, so latency is W+1 edges from start-sample
- Result registers are written only by accepted ops. In IDLE and MUL they hold their value; MUL intermediate values never appear on OUT.
- Reset asserted mid-MUL aborts the operation with no partial result.
- control/DATA_* may change freely once start is accepted.

## Test plan
- W=8, ADD A=0x7F B=0x01 → one edge later OUT=0x80, OVF=1, N=1, CO=0, Z=0, done=1 for one cycle, ready=1 throughout.
- SUB A=0x05 B=0x05 → OUT=0x00, Z=1, CO=1, OVF=0. Then CMP A=0x03 B=0x07 → OUT stays 0x00, N=1, CO=0, Z=0.
- MUL A=0xFF B=0xFF → ready=0 for 8 cycles, then OUT=0x01, OUT_HI=0xFE, CO=1, Z=0, done after 9 edges. A start with ADD inserted mid-MUL is ignored and the product is unchanged.
- After reset, four consecutive ACC with A=0x40 → OUT 0x40, 0x80 (OVF=1), 0xC0, 0x00 (CO=1, Z=1). done stays high all four cycles.
- Start MUL 0x12×0x34, assert rst_n=0 on edge k+4 → all outputs at reset values immediately, ready=1. A following MUL 0x12×0x34 yields {OUT_HI,OUT}=0x03A8.
- AND/OR/XOR with A=0xF0 B=0x3C → 0x30, 0xFC, 0xCC respectively; CO=OVF=0, OUT_HI=0, N per MSB.
